// File: rtl/ccu_pkg.sv
// Shared CCU snoop-port types: line states, CR bit positions, ACSNOOP encodings,
// the snoop request/response structs and the per-snoop response/state decode.
package ccu_pkg;

    localparam int unsigned AC_ADDR_WIDTH = 64;
    localparam int unsigned CD_DATA_WIDTH = 64;

    typedef enum logic [2:0] {
        INVALID      = 3'd0,
        UNIQUE_CLEAN = 3'd1,
        UNIQUE_DIRTY = 3'd2,
        SHARED_CLEAN = 3'd3,
        SHARED_DIRTY = 3'd4
    } line_state_e;

    localparam int CR_DT  = 0;
    localparam int CR_ERR = 1;
    localparam int CR_PD  = 2;
    localparam int CR_IS  = 3;
    localparam int CR_WU  = 4;

    localparam logic [3:0] SNP_READ_ONCE        = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED      = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN       = 4'b0010;
    localparam logic [3:0] SNP_READ_NOT_SHR_DTY = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE      = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED     = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID    = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID     = 4'b1101;

    typedef struct packed {
        logic [AC_ADDR_WIDTH-1:0] addr;
        logic [3:0]               snoop;
    } ac_chan_t;

    typedef struct packed {
        logic [CD_DATA_WIDTH-1:0] data;
        logic                     last;
    } cd_chan_t;

    typedef struct packed {
        ac_chan_t ac;
        logic     ac_valid;
        logic     cr_ready;
        logic     cd_ready;
    } ace_snoop_req_t;

    typedef struct packed {
        logic       ac_ready;
        logic       cr_valid;
        logic [4:0] cr_resp;
        logic       cd_valid;
        cd_chan_t   cd;
    } ace_snoop_resp_t;

    typedef struct packed {
        logic [4:0]  cr;
        line_state_e new_state;
    } snoop_dec_t;

    // Misses and unknown encodings leave the line untouched and answer CR=0.
    function automatic snoop_dec_t snoop_decode(input logic [3:0] snoop, input line_state_e st);
        snoop_dec_t d;
        logic hit, dirty, shared;
        hit    = (st != INVALID);
        dirty  = (st == UNIQUE_DIRTY) || (st == SHARED_DIRTY);
        shared = (st == SHARED_CLEAN) || (st == SHARED_DIRTY);
        d.cr        = '0;
        d.new_state = st;
        if (hit) begin
            case (snoop)
                SNP_READ_ONCE: begin
                    d.cr[CR_DT] = 1'b1;
                    d.cr[CR_IS] = 1'b1;
                    d.cr[CR_WU] = ~shared;
                end
                SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NOT_SHR_DTY: begin
                    d.cr[CR_DT] = 1'b1;
                    d.cr[CR_IS] = 1'b1;
                    d.cr[CR_PD] = dirty;
                    d.cr[CR_WU] = ~shared;
                    d.new_state = SHARED_CLEAN;
                end
                SNP_READ_UNIQUE: begin
                    d.cr[CR_DT] = 1'b1;
                    d.cr[CR_PD] = dirty;
                    d.cr[CR_WU] = ~shared;
                    d.new_state = INVALID;
                end
                SNP_CLEAN_INVALID: begin
                    d.cr[CR_DT] = dirty;
                    d.cr[CR_PD] = dirty;
                    d.cr[CR_WU] = ~shared;
                    d.new_state = INVALID;
                end
                SNP_CLEAN_SHARED: begin
                    d.cr[CR_DT] = dirty;
                    d.cr[CR_PD] = dirty;
                    d.cr[CR_IS] = 1'b1;
                    d.cr[CR_WU] = ~shared;
                    d.new_state = shared ? SHARED_CLEAN : UNIQUE_CLEAN;
                end
                SNP_MAKE_INVALID: begin
                    d.cr[CR_WU] = ~shared;
                    d.new_state = INVALID;
                end
                default: ;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/ace_snoop_cd_serializer.sv
// Holds the snooped line and streams it out as LineWidth/DataWidth CD beats, beat 0 first.
// Latency: first beat valid the cycle after start_i; one beat per cycle with cd_ready high.
// Backpressure: beat, data and last held while cd_ready_i is low; counter moves only on handshake.
module ace_snoop_cd_serializer #(
    parameter int unsigned LineWidth = 512,
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [LineWidth-1:0] line_i,
    input  logic                 start_i,
    input  logic                 cd_ready_i,
    output logic                 cd_valid_o,
    output logic [DataWidth-1:0] cd_data_o,
    output logic                 cd_last_o,
    output logic                 done_o
);

    localparam int unsigned Beats = LineWidth / DataWidth;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

    logic [LineWidth-1:0] line_q;
    logic [CntW-1:0]      beat_q;
    logic                 valid_q;
    logic                 beat_hs;

    assign cd_valid_o = valid_q;
    assign cd_data_o  = line_q[beat_q*DataWidth +: DataWidth];
    assign cd_last_o  = valid_q && (beat_q == CntW'(Beats - 1));
    assign beat_hs    = valid_q && cd_ready_i;
    assign done_o     = beat_hs && cd_last_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_q  <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_i) begin
                line_q <= line_i;
            end
            if (start_i) begin
                valid_q <= 1'b1;
            end else if (done_o) begin
                valid_q <= 1'b0;
            end
            if (beat_hs) begin
                beat_q <= cd_last_o ? '0 : beat_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: AC accept, line lookup, state update, CR response, CD line data.
// Latency: AC->lookup 1, ->update 1 (if state changes), ->CR 1, ->CD; ACE_SNOOP_RSP_CD_OVERLAP_EN merges CR and CD.
// Backpressure: one snoop in flight; ac_ready only in IDLE, every valid held until its ready.
module ace_snoop_responder
    import ccu_pkg::*;
#(
    parameter int unsigned LineWidth    = 512,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned AddrWidth    = 64,
    parameter type         snoop_req_t  = ace_snoop_req_t,
    parameter type         snoop_resp_t = ace_snoop_resp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  snoop_req_t           snoop_req_i,
    output snoop_resp_t          snoop_resp_o,
    output logic                 lookup_valid_o,
    output logic [AddrWidth-1:0] lookup_addr_o,
    input  logic                 lookup_ready_i,
    input  logic [2:0]           lookup_state_i,
    input  logic [LineWidth-1:0] lookup_data_i,
    output logic                 upd_valid_o,
    output logic [AddrWidth-1:0] upd_addr_o,
    output logic [2:0]           upd_state_o,
    input  logic                 upd_ready_i
);

`ifdef ACE_SNOOP_RSP_CD_OVERLAP_EN
    localparam bit Overlap = 1'b1;
`else
    localparam bit Overlap = 1'b0;
`endif

    localparam logic [AddrWidth-1:0] OffsetMask = AddrWidth'(LineWidth / 8 - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_LOOKUP, ST_UPDATE, ST_CR, ST_CD, ST_RESP} fsm_e;

    fsm_e                 state_q, state_d, resp_state;
    logic [AddrWidth-1:0] addr_q;
    logic [3:0]           snoop_q;
    logic [4:0]           cr_q;
    line_state_e          new_state_q;
    logic                 cr_done_q;
    snoop_dec_t           dec;
    logic                 ac_hs, lookup_hs, cr_valid, cr_hs, need_upd;
    logic                 cd_start, cd_valid, cd_last, cd_done;
    logic [DataWidth-1:0] cd_data;

    assign resp_state     = Overlap ? ST_RESP : ST_CR;
    assign dec            = snoop_decode(snoop_q, line_state_e'(lookup_state_i));
    assign need_upd       = (dec.new_state != line_state_e'(lookup_state_i));
    assign ac_hs          = (state_q == ST_IDLE) && snoop_req_i.ac_valid;
    assign lookup_valid_o = (state_q == ST_LOOKUP);
    assign lookup_hs      = lookup_valid_o && lookup_ready_i;
    assign lookup_addr_o  = addr_q;
    assign upd_valid_o    = (state_q == ST_UPDATE);
    assign upd_addr_o     = addr_q;
    assign upd_state_o    = new_state_q;
    assign cr_valid       = (state_q == ST_CR) || ((state_q == ST_RESP) && !cr_done_q);
    assign cr_hs          = cr_valid && snoop_req_i.cr_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            snoop_q     <= '0;
            cr_q        <= '0;
            new_state_q <= INVALID;
            cr_done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ac_hs) begin
                addr_q  <= snoop_req_i.ac.addr & ~OffsetMask;
                snoop_q <= snoop_req_i.ac.snoop;
            end
            if (lookup_hs) begin
                cr_q        <= dec.cr;
                new_state_q <= dec.new_state;
            end
            if (state_d == ST_IDLE) begin
                cr_done_q <= 1'b0;
            end else if (cr_hs) begin
                cr_done_q <= 1'b1;
            end
        end
    end

    // In overlap mode the CD stream is launched on entry to RESP so both channels rise together.
    always_comb begin
        state_d  = state_q;
        cd_start = 1'b0;
        case (state_q)
            ST_IDLE: if (ac_hs) state_d = ST_LOOKUP;
            ST_LOOKUP: begin
                if (lookup_hs) begin
                    if (need_upd) begin
                        state_d = ST_UPDATE;
                    end else begin
                        state_d  = resp_state;
                        cd_start = Overlap && dec.cr[CR_DT];
                    end
                end
            end
            ST_UPDATE: begin
                if (upd_ready_i) begin
                    state_d  = resp_state;
                    cd_start = Overlap && cr_q[CR_DT];
                end
            end
            ST_CR: begin
                if (cr_hs) begin
                    state_d  = cr_q[CR_DT] ? ST_CD : ST_IDLE;
                    cd_start = cr_q[CR_DT];
                end
            end
            ST_CD: if (cd_done) state_d = ST_IDLE;
            ST_RESP: begin
                if ((cr_done_q || cr_hs) && (!cd_valid || cd_done)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ace_snoop_cd_serializer #(
        .LineWidth (LineWidth),
        .DataWidth (DataWidth)
    ) u_cd_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (lookup_hs),
        .line_i     (lookup_data_i),
        .start_i    (cd_start),
        .cd_ready_i (snoop_req_i.cd_ready),
        .cd_valid_o (cd_valid),
        .cd_data_o  (cd_data),
        .cd_last_o  (cd_last),
        .done_o     (cd_done)
    );

    always_comb begin
        snoop_resp_o          = '0;
        snoop_resp_o.ac_ready = (state_q == ST_IDLE);
        snoop_resp_o.cr_valid = cr_valid;
        snoop_resp_o.cr_resp  = cr_q;
        snoop_resp_o.cd_valid = cd_valid;
        snoop_resp_o.cd.data  = cd_data;
        snoop_resp_o.cd.last  = cd_last;
    end

endmodule
